note_judge: RTL and testbench
=============================

# note_judge

Player-input judging stage directly downstream of the song engine. Each game frame it compares the 12 player keys against the engine's current one-hot note and counts how many frames of the note were held correctly. When the note ends it grades it perfect, good or miss, then updates score, combo and lives. It also runs the start / play / game-over state machine that the display and sound stages read.

## Interface
Parameters:
- LIVES_INIT, 3: lives at game start; range 1–3.
- PTS_PERFECT, 4: points added for a perfect note.
- PTS_GOOD, 2: points added for a good note.

Ports:
- game_clock, in, 1: the one clock; one rising edge per game frame. Reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- start, in, 1: one-cycle pulse that begins a game.
- curr_note, in, 12: one-hot current note from the engine. All-zero means a rest.
- hold_length, in, 4: length of the current note in frames.
- keys, in, 12: player keys, synchronized and debounced, active-high.
- score, out, 16: running score, saturating.
- combo, out, 8: consecutive good-or-better notes, saturating.
- lives, out, 2: remaining lives.
- judged_hit, out, 1: one-cycle pulse when a note grades good or perfect.
- judged_perfect, out, 1: one-cycle pulse when a note grades perfect; always coincides with judged_hit.
- judged_miss, out, 1: one-cycle pulse when a note grades miss.
- playing, out, 1: high in PLAY.
- game_over, out, 1: high in OVER.

## Operation
States: IDLE, PLAY, OVER.
- IDLE: counters are held.
  - On start: go to PLAY and set lives to LIVES_INIT, score to 0, combo to 0.
  - On the same edge, load note_reg ← curr_note, len ← max(hold_length, 1), remaining ← max(hold_length, 1), correct ← 0.
- PLAY: every cycle compute a per-frame match.
  - match = |(keys & note_reg) && ~|(keys & ~note_reg) (at least one note key down, no wrong key).
  - correct_nx = correct + match.
  - When remaining > 1: remaining − 1, correct ← correct_nx.
  - When remaining == 1 the note ends, and is judged against correct_nx:
    - Rest (note_reg == 0): no pulse; score, combo and lives unchanged.
    - Perfect, correct_nx == len: judged_hit and judged_perfect pulse; score += PTS_PERFECT; combo += 1.
    - Good, 2·correct_nx ≥ len: judged_hit pulses; score += PTS_GOOD; combo += 1.
    - Otherwise miss: judged_miss pulses; combo ← 0; lives − 1.
    - On the same edge, reload note_reg, len, remaining and correct from the inputs, as in IDLE.
  - Lives reaching 0 on a miss: go to OVER on that edge and do not reload.
- OVER: score and combo are frozen; lives = 0.
  - start behaves as it does in IDLE.
- start asserted while in PLAY is ignored.
- Arithmetic:
  - score saturates at 16'hFFFF.
  - combo saturates at 8'hFF.
  - correct and remaining are 4 bits; correct_nx ≤ len ≤ 15, so they cannot overflow.
  - The 2·correct_nx compare is done at 5 bits.
- hold_length = 0 is treated as 1.
- keys are sampled only in PLAY.

## Timing
- All outputs are registered. Reset values:
  - state IDLE;
  - score 0, combo 0, lives 0;
  - all pulses 0;
  - playing 0, game_over 0.
- Reset has priority over start and over judging on the same edge.
- Reset in PLAY goes to IDLE on the next edge; the in-progress note is discarded without a pulse.
- A note of length L is sampled for exactly L cycles, including the start or reload cycle.
- Judge pulses and score / combo / lives updates appear on the edge after the final frame of the note, together with the reload of the next note.
- Consecutive notes are judged back-to-back with no gap cycle.
- The engine updates curr_note and hold_length once per note. The judge samples them only on start or reload edges, so intermediate values are don't-care.

## Structure
- Package note_judge_pkg holds:
  - the state enum {IDLE, PLAY, OVER};
  - grade constants;
  - default values for PTS_PERFECT, PTS_GOOD and LIVES_INIT;
  - the widths NOTE_W = 12 and LEN_W = 4.
- Sub-module score_keeper (natural split) owns score, combo and lives.
  - Its inputs are a grade strobe and a grade code; it handles all saturation.
  - Clear-on-start is its only other control.
- The match logic stays inline in note_judge.

## Test plan
- Perfect hit: start; curr_note = 12'h001, hold_length = 2; keys = 12'h001 for 2 cycles. Expect judged_hit and judged_perfect; score = 4, combo = 1.
- Good: note 12'h004, length 3; correct key held 2 of 3 frames. Expect judged_hit only; score += 2.
- Wrong key: note 12'h100, length 2; keys = 12'h101 both frames. Expect judged_miss; combo = 0; lives 3→2.
- Game over: three consecutive misses from the start of a game. Expect game_over = 1 on the edge of the third judge; no further pulses; a later start restores lives = 3, score = 0.
- Rest: curr_note = 0, length 4, any keys. Expect no pulses for 4 cycles; score, combo and lives unchanged.
- Saturation and reset: preload score = 16'hFFFE, then a perfect hit. Expect score = 16'hFFFF. Assert reset mid-note: expect IDLE next edge, all outputs at reset values, no pulse.

Source files
------------

// File: rtl/note_judge_pkg.sv
// Shared types, widths and default tuning for the note judging stage.
package note_judge_pkg;

    localparam int unsigned NOTE_W  = 12;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned COMBO_W = 8;
    localparam int unsigned LIVES_W = 2;

    localparam int unsigned PTS_PERFECT_DEF = 4;
    localparam int unsigned PTS_GOOD_DEF    = 2;
    localparam int unsigned LIVES_INIT_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2
    } grade_e;

endpackage

// File: rtl/note_judge_score_keeper.sv
// Score, combo and lives bookkeeping; applies one grade per strobe with saturation.
module score_keeper
    import note_judge_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
    parameter int unsigned PTS_PERFECT = PTS_PERFECT_DEF,
    parameter int unsigned PTS_GOOD    = PTS_GOOD_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               grade_vld_i,
    input  grade_e             grade_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [COMBO_W-1:0] combo_o,
    output logic [LIVES_W-1:0] lives_o
);

    localparam int unsigned SUM_W = SCORE_W + 1;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] pts_c;
    logic [SUM_W-1:0]   sum_c;

    always_comb begin
        pts_c   = (grade_i == GRADE_PERFECT) ? SCORE_W'(PTS_PERFECT) : SCORE_W'(PTS_GOOD);
        sum_c   = {1'b0, score_q} + SUM_W'(pts_c);
        score_d = score_q;
        combo_d = combo_q;
        lives_d = lives_q;
        if (clear_i) begin
            score_d = '0;
            combo_d = '0;
            lives_d = LIVES_W'(LIVES_INIT);
        end else if (grade_vld_i) begin
            if (grade_i == GRADE_MISS) begin
                combo_d = '0;
                lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
            end else begin
                // carry out of the 17-bit sum means the score pinned at max
                score_d = sum_c[SCORE_W] ? {SCORE_W{1'b1}} : sum_c[SCORE_W-1:0];
                combo_d = (combo_q == {COMBO_W{1'b1}}) ? combo_q : combo_q + COMBO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            score_q <= '0;
            combo_q <= '0;
            lives_q <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            lives_q <= lives_d;
        end
    end

    assign score_o = score_q;
    assign combo_o = combo_q;
    assign lives_o = lives_q;

endmodule

// File: rtl/note_judge.sv
// Per-frame key matching against the engine's current note, note grading and game FSM.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
    parameter int unsigned PTS_PERFECT = PTS_PERFECT_DEF,
    parameter int unsigned PTS_GOOD    = PTS_GOOD_DEF
) (
    input  logic               game_clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NOTE_W-1:0]  curr_note,
    input  logic [LEN_W-1:0]   hold_length,
    input  logic [NOTE_W-1:0]  keys,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [LIVES_W-1:0] lives,
    output logic               judged_hit,
    output logic               judged_perfect,
    output logic               judged_miss,
    output logic               playing,
    output logic               game_over
);

    state_e             state_q, state_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   correct_q, correct_d;
    logic               hit_q, perfect_q, miss_q;
    logic               playing_q, over_q;

    logic               match_c;
    logic [LEN_W-1:0]   correct_nx_c;
    logic [LEN_W:0]     dbl_c;
    logic [LEN_W-1:0]   load_len_c;
    logic               load_c;
    logic               clear_c;
    logic               grade_vld_c;
    grade_e             grade_c;

    assign match_c      = (|(keys & note_q)) && !(|(keys & ~note_q));
    assign correct_nx_c = correct_q + LEN_W'(match_c);
    assign dbl_c        = {correct_nx_c, 1'b0};
    assign load_len_c   = (hold_length == '0) ? LEN_W'(1) : hold_length;

    // next state, note tracking and grading
    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        len_d       = len_q;
        rem_d       = rem_q;
        correct_d   = correct_q;
        load_c      = 1'b0;
        clear_c     = 1'b0;
        grade_vld_c = 1'b0;
        grade_c     = GRADE_MISS;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    clear_c = 1'b1;
                    load_c  = 1'b1;
                end
            end
            PLAY: begin
                if (rem_q > LEN_W'(1)) begin
                    rem_d     = rem_q - LEN_W'(1);
                    correct_d = correct_nx_c;
                end else begin
                    load_c = 1'b1;
                    if (note_q != '0) begin
                        grade_vld_c = 1'b1;
                        if (correct_nx_c == len_q) begin
                            grade_c = GRADE_PERFECT;
                        end else if (dbl_c >= {1'b0, len_q}) begin
                            grade_c = GRADE_GOOD;
                        end else begin
                            grade_c = GRADE_MISS;
                            if (lives == LIVES_W'(1)) begin
                                state_d = OVER;
                                load_c  = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_c) begin
            note_d    = curr_note;
            len_d     = load_len_c;
            rem_d     = load_len_c;
            correct_d = '0;
        end
    end

    always_ff @(posedge game_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            note_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            correct_q <= '0;
            hit_q     <= 1'b0;
            perfect_q <= 1'b0;
            miss_q    <= 1'b0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            correct_q <= correct_d;
            hit_q     <= grade_vld_c && (grade_c != GRADE_MISS);
            perfect_q <= grade_vld_c && (grade_c == GRADE_PERFECT);
            miss_q    <= grade_vld_c && (grade_c == GRADE_MISS);
            playing_q <= (state_d == PLAY);
            over_q    <= (state_d == OVER);
        end
    end

    score_keeper #(
        .LIVES_INIT  (LIVES_INIT),
        .PTS_PERFECT (PTS_PERFECT),
        .PTS_GOOD    (PTS_GOOD)
    ) u_score_keeper (
        .clk_i       (game_clock),
        .rst_i       (reset),
        .clear_i     (clear_c),
        .grade_vld_i (grade_vld_c),
        .grade_i     (grade_c),
        .score_o     (score),
        .combo_o     (combo),
        .lives_o     (lives)
    );

    assign judged_hit     = hit_q;
    assign judged_perfect = perfect_q;
    assign judged_miss    = miss_q;
    assign playing        = playing_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed-vector bench for note_judge with hand-computed expectations.
module tb_note_judge;

    logic        game_clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] curr_note;
    logic [3:0]  hold_length;
    logic [11:0] keys;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [1:0]  lives;
    logic        judged_hit;
    logic        judged_perfect;
    logic        judged_miss;
    logic        playing;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 game_clock = ~game_clock;

    note_judge dut (
        .game_clock     (game_clock),
        .reset          (reset),
        .start          (start),
        .curr_note      (curr_note),
        .hold_length    (hold_length),
        .keys           (keys),
        .score          (score),
        .combo          (combo),
        .lives          (lives),
        .judged_hit     (judged_hit),
        .judged_perfect (judged_perfect),
        .judged_miss    (judged_miss),
        .playing        (playing),
        .game_over      (game_over)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge game_clock);
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic h, input logic p, input logic m);
        check_eq({tag, ".hit"},     32'(judged_hit),     32'(h));
        check_eq({tag, ".perfect"}, 32'(judged_perfect), 32'(p));
        check_eq({tag, ".miss"},    32'(judged_miss),    32'(m));
    endtask

    task automatic check_counts(input string tag, input int s, input int c, input int l);
        check_eq({tag, ".score"}, 32'(score), 32'(s));
        check_eq({tag, ".combo"}, 32'(combo), 32'(c));
        check_eq({tag, ".lives"}, 32'(lives), 32'(l));
    endtask

    task automatic check_idle_reset(input string tag);
        check_counts(tag, 0, 0, 0);
        check_pulses(tag, 1'b0, 1'b0, 1'b0);
        check_eq({tag, ".playing"},   32'(playing),   32'd0);
        check_eq({tag, ".game_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; curr_note = '0; hold_length = '0; keys = '0;
        tick(); tick();
        check_idle_reset("reset");
        reset = 1'b0;

        // perfect: note 001, length 2, key held both frames
        curr_note = 12'h001; hold_length = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start.playing", 32'(playing), 32'd1);
        check_counts("start", 0, 0, 3);
        keys = 12'h001;
        tick();
        check_pulses("perf.f1", 1'b0, 1'b0, 1'b0);
        curr_note = 12'h004; hold_length = 4'd3;
        tick();
        check_pulses("perf", 1'b1, 1'b1, 1'b0);
        check_counts("perf", 4, 1, 3);

        // good: note 004, length 3, correct 2 of 3
        keys = 12'h004;
        tick();
        check_pulses("good.f1", 1'b0, 1'b0, 1'b0);
        tick();
        keys = 12'h000; curr_note = 12'h100; hold_length = 4'd2;
        tick();
        check_pulses("good", 1'b1, 1'b0, 1'b0);
        check_counts("good", 6, 2, 3);

        // wrong key alongside the right one
        keys = 12'h101;
        tick();
        curr_note = 12'h000; hold_length = 4'd4;
        tick();
        check_pulses("wrong", 1'b0, 1'b0, 1'b1);
        check_counts("wrong", 6, 0, 2);

        // rest: four frames, never judged
        keys = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                curr_note = 12'h002; hold_length = 4'd0;
            end
            tick();
            check_pulses($sformatf("rest.f%0d", i), 1'b0, 1'b0, 1'b0);
        end
        check_counts("rest", 6, 0, 2);

        // two misses on zero-length notes end the game
        keys = 12'h000;
        tick();
        check_pulses("miss1", 1'b0, 1'b0, 1'b1);
        check_counts("miss1", 6, 0, 1);
        tick();
        check_pulses("miss2", 1'b0, 1'b0, 1'b1);
        check_counts("miss2", 6, 0, 0);
        check_eq("miss2.game_over", 32'(game_over), 32'd1);
        check_eq("miss2.playing",   32'(playing),   32'd0);
        tick(); tick();
        check_pulses("over.quiet", 1'b0, 1'b0, 1'b0);
        check_counts("over.frozen", 6, 0, 0);

        // fresh game, three misses from the start
        curr_note = 12'h001; hold_length = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check_counts("restart", 0, 0, 3);
        check_eq("restart.game_over", 32'(game_over), 32'd0);
        tick();
        check_counts("go.m1", 0, 0, 2);
        tick();
        check_counts("go.m2", 0, 0, 1);
        check_eq("go.m2.game_over", 32'(game_over), 32'd0);
        tick();
        check_pulses("go.m3", 1'b0, 1'b0, 1'b1);
        check_counts("go.m3", 0, 0, 0);
        check_eq("go.m3.game_over", 32'(game_over), 32'd1);
        start = 1'b0;
        tick();
        check_pulses("go.after", 1'b0, 1'b0, 1'b0);

        // run score up to saturation with back-to-back one-frame perfects
        curr_note = 12'h001; hold_length = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        keys = 12'h001;
        for (int i = 0; i < 16382; i++) tick();
        check_counts("sat.fff8", 16'hFFF8, 8'hFF, 3);
        hold_length = 4'd2;
        tick();
        check_counts("sat.fffc", 16'hFFFC, 8'hFF, 3);
        tick();
        keys = 12'h000; hold_length = 4'd1;
        tick();
        check_pulses("sat.good", 1'b1, 1'b0, 1'b0);
        check_counts("sat.fffe", 16'hFFFE, 8'hFF, 3);
        keys = 12'h001; hold_length = 4'd3;
        tick();
        check_pulses("sat.perf", 1'b1, 1'b1, 1'b0);
        check_counts("sat.ffff", 16'hFFFF, 8'hFF, 3);

        // reset mid-note discards it
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle_reset("midreset");
        reset = 1'b0;
        tick();
        check_idle_reset("midreset.after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
